// File: rtl/bsg_skid_pkg.sv
// Shared types and constants for the two-entry skid buffer.
package bsg_skid_pkg;

   // Occupancy-encoded buffer state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   // Number of entries the buffer can hold.
   localparam logic [1:0] skid_depth_lp = 2'd2;

   // Number of valid entries represented by a state.
   function automatic logic [1:0] skid_count(input skid_state_e s);
      case (s)
         EMPTY:   return 2'd0;
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/bsg_dff_en_width_p9.sv
// Enable-gated storage register. harden_p selects a per-bit flop
// implementation so each bit maps to its own enable flop cell; otherwise a
// plain vector register is inferred. Contents are not reset.
module bsg_dff_en_width_p9 #(
   parameter int width_p  = 9,
   parameter bit harden_p = 1'b1
) (
   input  logic               clk_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [width_p-1:0] data_q;

   generate
      if (harden_p) begin : g_hard
         genvar gi;
         for (gi = 0; gi < width_p; gi++) begin : g_bit
            // Per-bit enable flop.
            always_ff @(posedge clk_i) begin
               if (en_i) begin
                  data_q[gi] <= data_i[gi];
               end
            end
         end
      end else begin : g_soft
         // Vector enable register.
         always_ff @(posedge clk_i) begin
            if (en_i) begin
               data_q <= data_i;
            end
         end
      end
   endgenerate

   assign data_o = data_q;

endmodule

// File: rtl/bsg_skid_buffer_width_p9.sv
// Two-entry elastic buffer with ready/valid input and valid/yumi output.
// Head holds the word presented on data_o, tail holds the second word.
// ready_o and v_o come straight from the state register, so there is no
// combinational path from yumi_i to ready_o; the only combinational term on
// ready_o is reset_i, which holds the upstream off while reset is asserted.
module bsg_skid_buffer_width_p9
   import bsg_skid_pkg::*;
#(
   parameter int width_p  = 9,
   parameter bit harden_p = 1'b1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   skid_state_e        state_q, state_d;
   logic               enq, deq;
   logic               head_en, tail_en, head_sel_tail;
   logic [width_p-1:0] head_d, head_q, tail_q;

   assign v_o     = (state_q != EMPTY);
   assign ready_o = ~reset_i & (skid_count(state_q) < skid_depth_lp);
   assign data_o  = head_q;

   assign enq = v_i & ready_o;
   // A yumi with nothing at the head is ignored so the state cannot underflow.
   assign deq = yumi_i & v_o & ~reset_i;

   // Next-state and storage-enable decode.
   always_comb begin
      state_d       = state_q;
      head_en       = 1'b0;
      tail_en       = 1'b0;
      head_sel_tail = 1'b0;
      case (state_q)
         EMPTY: begin
            if (enq) begin
               state_d = ONE;
               head_en = 1'b1;
            end
         end
         ONE: begin
            if (enq && !deq) begin
               state_d = TWO;
               tail_en = 1'b1;
            end else if (!enq && deq) begin
               state_d = EMPTY;
            end else if (enq && deq) begin
               // Bypass: new word replaces the consumed head, no bubble.
               head_en = 1'b1;
            end
         end
         TWO: begin
            if (deq) begin
               state_d       = ONE;
               head_en       = 1'b1;
               head_sel_tail = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   assign head_d = head_sel_tail ? tail_q : data_i;

   // State register; reset discards both entries.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   bsg_dff_en_width_p9 #(
      .width_p (width_p),
      .harden_p(harden_p)
   ) head_reg (
      .clk_i (clk_i),
      .en_i  (head_en),
      .data_i(head_d),
      .data_o(head_q)
   );

   bsg_dff_en_width_p9 #(
      .width_p (width_p),
      .harden_p(harden_p)
   ) tail_reg (
      .clk_i (clk_i),
      .en_i  (tail_en),
      .data_i(data_i),
      .data_o(tail_q)
   );

   // Consuming from an empty buffer is a protocol error.
   a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
      (yumi_i |-> v_o));

endmodule

// File: tb/tb_bsg_skid_buffer_width_p9.sv
// Directed and scoreboard-driven bench for the two-entry skid buffer.
module tb_bsg_skid_buffer_width_p9;

   logic       clk;
   logic       reset_i;
   logic       v_i;
   logic [8:0] data_i;
   logic       ready_o;
   logic       v_o;
   logic [8:0] data_o;
   logic       yumi_i;

   int check_cnt = 0;
   int err_cnt   = 0;

   bsg_skid_buffer_width_p9 #(.width_p(9), .harden_p(1'b1)) dut (
      .clk_i  (clk),
      .reset_i(reset_i),
      .v_i    (v_i),
      .data_i (data_i),
      .ready_o(ready_o),
      .v_o    (v_o),
      .data_o (data_o),
      .yumi_i (yumi_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      check_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [8:0] sb_q[$];
   logic [8:0] exp_w;
   logic       pend;
   int         pops;

   initial begin
      reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = 9'h000;

      // Reset then idle
      tick();
      chk("rst_v", v_o, 0);
      chk("rst_rdy", ready_o, 0);
      tick();
      chk("rst_v2", v_o, 0);
      chk("rst_rdy2", ready_o, 0);
      reset_i = 1'b0;
      #1;
      chk("rel_rdy", ready_o, 1);
      tick();
      chk("idle_v", v_o, 0);
      chk("idle_rdy", ready_o, 1);
      $display("txn reset/idle");

      // Single word
      v_i = 1'b1; data_i = 9'h0A5;
      tick();
      v_i = 1'b0;
      chk("one_v", v_o, 1);
      chk("one_data", data_o, 9'h0A5);
      chk("one_rdy", ready_o, 1);
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      chk("one_pop_v", v_o, 0);
      $display("txn single word 0a5");

      // Fill and stall
      v_i = 1'b1; data_i = 9'h001;
      tick();
      data_i = 9'h002;
      tick();
      chk("fill_rdy", ready_o, 0);
      chk("fill_v", v_o, 1);
      chk("fill_data", data_o, 9'h001);
      data_i = 9'h003;
      tick();
      chk("stall_data", data_o, 9'h001);
      chk("stall_rdy", ready_o, 0);
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      chk("unstall_data", data_o, 9'h002);
      chk("unstall_rdy", ready_o, 1);
      tick();
      v_i = 1'b0;
      chk("third_data", data_o, 9'h002);
      chk("third_rdy", ready_o, 0);
      yumi_i = 1'b1;
      tick();
      chk("drain_data", data_o, 9'h003);
      chk("drain_v", v_o, 1);
      tick();
      yumi_i = 1'b0;
      chk("drain_empty", v_o, 0);
      $display("txn fill/stall 001 002 003");

      // Streaming
      v_i = 1'b1; data_i = 9'h100;
      tick();
      chk("strm_first", data_o, 9'h100);
      for (int i = 1; i < 16; i++) begin
         data_i = 9'h100 + 9'(i);
         yumi_i = 1'b1;
         tick();
         chk("strm_data", data_o, 16'h100 + 16'(i));
         chk("strm_rdy", ready_o, 1);
         chk("strm_v", v_o, 1);
      end
      v_i = 1'b0;
      tick();
      yumi_i = 1'b0;
      chk("strm_end_v", v_o, 0);
      $display("txn streaming 100..10f");

      // Reset mid-operation
      v_i = 1'b1; data_i = 9'h1FF;
      tick();
      data_i = 9'h0FF;
      tick();
      v_i = 1'b0;
      chk("mid_full_rdy", ready_o, 0);
      reset_i = 1'b1;
      #1;
      chk("mid_rst_rdy", ready_o, 0);
      tick();
      reset_i = 1'b0;
      #1;
      chk("mid_after_v", v_o, 0);
      chk("mid_after_rdy", ready_o, 1);
      v_i = 1'b1; data_i = 9'h055;
      tick();
      v_i = 1'b0;
      chk("mid_push_data", data_o, 9'h055);
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      chk("mid_dropped_v", v_o, 0);
      $display("txn reset mid-operation, push 055");

      // Random traffic against a scoreboard
      pend = 1'b0;
      pops = 0;
      for (int c = 0; c < 10000; c++) begin
         chk("rnd_v", v_o, (sb_q.size() != 0) ? 1 : 0);
         chk("rnd_rdy", ready_o, (sb_q.size() < 2) ? 1 : 0);
         if (!pend) begin
            v_i = 1'($urandom_range(0, 1));
            data_i = 9'($urandom);
            pend = v_i;
         end
         yumi_i = v_o & 1'($urandom_range(0, 1));
         if (yumi_i) begin
            exp_w = sb_q.pop_front();
            chk("rnd_data", data_o, exp_w);
            if (pops < 20) $display("txn rnd pop %03h", exp_w);
            pops++;
         end
         if (v_i && ready_o) begin
            sb_q.push_back(data_i);
            pend = 1'b0;
         end
         tick();
      end
      v_i = 1'b0; yumi_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule
